fetch_arbiter: RTL

FETCH_ARBITER -- requirements
Module: fetch_arbiter

---
 rtl/fetch_arbiter_pkg.sv | 18 +
 rtl/tag_queue.sv | 64 ++++++
 rtl/fetch_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/fetch_arbiter_pkg.sv
// Shared tag width, arbiter state type and counter helpers for the fetch arbiter.
// The event tag width lives here so every fetch-path block agrees on it.
package fetch_arbiter_pkg;

  localparam int EVENT_TAG_BITS = 48;
  localparam int DROP_CNT_W     = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } arb_state_e;

  // Drop counters stick at all-ones rather than wrapping back to zero.
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/tag_queue.sv
// Small circular FIFO holding event tags.
// full/empty are decoded from an occupancy count; a push while full is discarded.
module tag_queue
  import fetch_arbiter_pkg::*;
#(
  parameter int DATA_W = EVENT_TAG_BITS,
  parameter int QDEPTH = 4
) (
  input  logic                        dreqclk,
  input  logic                        resetn_dreqclk,
  input  logic                        push,
  input  logic [DATA_W-1:0]           push_data,
  input  logic                        pop,
  output logic [DATA_W-1:0]           head,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(QDEPTH+1)-1:0] count
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(QDEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);

  logic [DATA_W-1:0] mem [QDEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  // Full is judged on the pre-edge count, so a same-cycle pop never makes room.
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge dreqclk or negedge resetn_dreqclk) begin
    if (!resetn_dreqclk) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge dreqclk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/fetch_arbiter.sv
// Arbitrates PREFETCH and DATAREQ tags onto a single fetch request/acknowledge
// handshake, with starvation protection, prefetch-hit bypass and an ack timeout.
module fetch_arbiter
  import fetch_arbiter_pkg::*;
#(
  parameter int QDEPTH       = 4,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 1024
) (
  input  logic                      dreqclk,
  input  logic                      resetn_dreqclk,
  input  logic                      pref_start,
  input  logic [EVENT_TAG_BITS-1:0] pref_tag,
  input  logic                      dreq_start,
  input  logic [EVENT_TAG_BITS-1:0] dreq_tag,
  input  logic                      tag_valid,
  output logic                      tag_fetch,
  output logic [EVENT_TAG_BITS-1:0] evt_tag_fetch,
  output logic                      fetch_is_pref,
  output logic                      dreq_hit,
  output logic                      timeout_err,
  output logic                      busy,
  output logic                      pref_full,
  output logic                      dreq_full,
  output logic [DROP_CNT_W-1:0]     pref_drop_cnt,
  output logic [DROP_CNT_W-1:0]     dreq_drop_cnt
);

  localparam int CW = $clog2(QDEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] WAIT_LAST  = TW'(TIMEOUT - 1);

  arb_state_e                state;
  logic [EVENT_TAG_BITS-1:0] pref_head;
  logic [EVENT_TAG_BITS-1:0] dreq_head;
  logic                      pref_empty;
  logic                      dreq_empty;
  logic [CW-1:0]             pref_cnt;
  logic [CW-1:0]             dreq_cnt;
  logic                      pref_pop;
  logic                      dreq_pop;
  logic                      arb_open;
  logic                      sel_pref;
  logic                      dreq_is_hit;
  logic                      issue_vld_p0;
  logic                      issue_pref_p0;
  logic [EVENT_TAG_BITS-1:0] issue_tag_p0;
  logic [SW-1:0]             dreq_streak;
  logic                      last_pref_valid;
  logic [EVENT_TAG_BITS-1:0] last_pref_tag;
  logic [TW-1:0]             wait_cnt;
  logic                      unused_cnt;

  tag_queue #(.DATA_W(EVENT_TAG_BITS), .QDEPTH(QDEPTH)) u_pref_q (
    .dreqclk        (dreqclk),
    .resetn_dreqclk (resetn_dreqclk),
    .push           (pref_start),
    .push_data      (pref_tag),
    .pop            (pref_pop),
    .head           (pref_head),
    .full           (pref_full),
    .empty          (pref_empty),
    .count          (pref_cnt)
  );

  tag_queue #(.DATA_W(EVENT_TAG_BITS), .QDEPTH(QDEPTH)) u_dreq_q (
    .dreqclk        (dreqclk),
    .resetn_dreqclk (resetn_dreqclk),
    .push           (dreq_start),
    .push_data      (dreq_tag),
    .pop            (dreq_pop),
    .head           (dreq_head),
    .full           (dreq_full),
    .empty          (dreq_empty),
    .count          (dreq_cnt)
  );

  assign unused_cnt = ^{pref_cnt, dreq_cnt};
  assign busy       = (state == ST_WAIT);

  // DREQ normally wins; PREFETCH takes the slot when DREQ is idle or has hogged it.
  assign arb_open    = (state == ST_IDLE) && !issue_vld_p0;
  assign sel_pref    = !pref_empty && (dreq_empty || (dreq_streak == STREAK_MAX));
  assign pref_pop    = arb_open && sel_pref;
  assign dreq_pop    = arb_open && !dreq_empty && !sel_pref;
  assign dreq_is_hit = last_pref_valid && (dreq_head == last_pref_tag);

  // Grant stage: popped head is held one cycle before it drives the fetch request.
  always_ff @(posedge dreqclk) begin
    if (pref_pop) begin
      issue_tag_p0 <= pref_head;
    end else if (dreq_pop) begin
      issue_tag_p0 <= dreq_head;
    end
  end

  always_ff @(posedge dreqclk or negedge resetn_dreqclk) begin
    if (!resetn_dreqclk) begin
      pref_drop_cnt <= '0;
      dreq_drop_cnt <= '0;
    end else begin
      if (pref_start && pref_full) begin
        pref_drop_cnt <= sat_inc(pref_drop_cnt);
      end
      if (dreq_start && dreq_full) begin
        dreq_drop_cnt <= sat_inc(dreq_drop_cnt);
      end
    end
  end

  always_ff @(posedge dreqclk or negedge resetn_dreqclk) begin
    if (!resetn_dreqclk) begin
      state           <= ST_IDLE;
      issue_vld_p0    <= 1'b0;
      issue_pref_p0   <= 1'b0;
      tag_fetch       <= 1'b0;
      evt_tag_fetch   <= '0;
      fetch_is_pref   <= 1'b0;
      dreq_hit        <= 1'b0;
      timeout_err     <= 1'b0;
      dreq_streak     <= '0;
      last_pref_valid <= 1'b0;
      last_pref_tag   <= '0;
      wait_cnt        <= '0;
    end else begin
      dreq_hit    <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (issue_vld_p0) begin
            issue_vld_p0  <= 1'b0;
            tag_fetch     <= 1'b1;
            evt_tag_fetch <= issue_tag_p0;
            fetch_is_pref <= issue_pref_p0;
            wait_cnt      <= '0;
            state         <= ST_WAIT;
          end else if (pref_pop) begin
            issue_vld_p0  <= 1'b1;
            issue_pref_p0 <= 1'b1;
            dreq_streak   <= '0;
          end else if (dreq_pop) begin
            // A DREQ for the tag the last prefetch already brought in needs no fetch.
            if (dreq_is_hit) begin
              dreq_hit        <= 1'b1;
              last_pref_valid <= 1'b0;
            end else begin
              issue_vld_p0  <= 1'b1;
              issue_pref_p0 <= 1'b0;
              if (!pref_empty && (dreq_streak != STREAK_MAX)) begin
                dreq_streak <= dreq_streak + 1'b1;
              end
            end
          end
        end
        ST_WAIT: begin
          if (tag_valid) begin
            tag_fetch <= 1'b0;
            state     <= ST_IDLE;
            if (fetch_is_pref) begin
              last_pref_tag   <= evt_tag_fetch;
              last_pref_valid <= 1'b1;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            tag_fetch   <= 1'b0;
            timeout_err <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
